mdio_master: RTL and testbench
==============================

// Module: mdio_master
// PURPOSE
//  Parametrised clause-22 MDIO (SMI) master for PHY management; next generation of our PHY-init SMI engine.
//  Accepts single read/write commands over a valid/ready handshake and drives an open-drain MDIO line.
//  Returns read data, PHY ACK status and an optional hardware poll-until-match result.
//  Sits between PHY init/status sequencers and the top-level MDIO pad (mdio_o/mdio_out_en/mdio_i).
// PARAMETERS
//  PRE_LEN   32  preamble length in MDC cycles, legal range 1..63 (0 rejected by elaboration assertion)
//  IDLE_GAP  4   released-line cycles after each frame, 1..255
//  POLL_MAX  16  max read attempts in poll mode, 1..255 (0 = unlimited)
// PORTS
//  clk1m        in   1   1 MHz system clock, also forwarded as MDC
//  rst          in   1   async active-low reset
//  mdc_o        out  1   MDC = clk1m, free running
//  mdio_i       in   1   MDIO pad input
//  mdio_o       out  1   MDIO pad output, constant 0 (open drain)
//  mdio_out_en  out  1   1 = drive line low; 0 = release (pull-up gives 1)
//  cmd_valid    in   1   command request
//  cmd_ready    out  1   engine idle, command accepted when cmd_valid&cmd_ready at posedge
//  cmd_rw       in   1   1 = read, 0 = write
//  cmd_poll     in   1   read only: repeat until (rdata & cmd_mask) == cmd_match
//  cmd_phy      in   5   PHY address
//  cmd_reg      in   5   register address
//  cmd_wdata    in   16  write data (ignored on read)
//  cmd_mask     in   16  poll mask
//  cmd_match    in   16  poll compare value
//  rsp_valid    out  1   one-cycle response strobe, no backpressure
//  rsp_rdata    out  16  last read data (held until next rsp_valid; 16'h0000 after a write)
//  rsp_nack     out  1   read: TA 2nd bit sampled 1 (no PHY); write: always 0
//  rsp_timeout  out  1   poll exhausted POLL_MAX attempts without match
//  busy         out  1   ~cmd_ready
// BEHAVIOUR
//  Reset: state IDLE, cmd_ready=1, busy=0, mdio_out_en=0, rsp_valid=0, rsp_rdata=0, rsp_nack=0, rsp_timeout=0.
//  Reset mid-frame releases the line on assertion (asynchronous); no response for the aborted command.
//  Command fields are registered at acceptance edge E0; later input changes are ignored.
//  States: IDLE -> PRE (PRE_LEN cycles) -> FRAME (32 cycles) -> DONE (1 cycle) -> GAP (IDLE_GAP cycles) -> IDLE or PRE.
//  PRE: line released from edge E0 for PRE_LEN cycles.
//  FRAME bit b (0..31) driven from edge E0+PRE_LEN+b, MSB first:
//   ST=01, OP=10 rd / 01 wr, PHY[4:0], REG[4:0], TA, DATA[15:0].
//  TA: write = 1,0; read = released, released. DATA: write = cmd_wdata; read = released.
//  Bit '1' or released => mdio_out_en=0; bit '0' => mdio_out_en=1.
//  Sampling: mdio_i at edge E0+PRE_LEN+b+1 is the value of frame bit b.
//   Read ack = sample of bit 15 == 0; read data bits 16..31 shift in MSB first.
//  DONE edge = E0+PRE_LEN+32: last data bit sampled.
//  Response at DONE, rsp_valid high for the following cycle, unless a poll retry applies:
//   rsp_rdata from shift register, rsp_nack set per above.
//  Poll mode (cmd_poll=1 and cmd_rw=1; ignored for writes):
//   Attempt counter starts at 1. At DONE: if match, or nack, or attempt==POLL_MAX, emit rsp.
//   rsp_timeout=1 only in the POLL_MAX-without-match case.
//   Otherwise no rsp; after GAP go to PRE with the same fields and attempt+1.
//   nack ends polling immediately (rsp_nack=1, rsp_timeout=0).
//  GAP always runs after DONE. cmd_ready rises at edge DONE+IDLE_GAP when no retry is pending.
//  Single-read latency: acceptance edge to rsp_valid edge = PRE_LEN+32 cycles (64 at defaults).
//  Back-to-back: a command presented while busy waits; none is dropped or queued.
//  Attempt counter is 8 bits and saturates at 255 with POLL_MAX=0 (unlimited; no wrap-induced timeout).
// TESTING
//  1. Write phy=1 reg=31 data=16'h0007 -> out_en pattern = ~(01_01_00001_11111_10_0000000000000111) after 32 released cycles; rsp_valid at E0+64, nack=0.
//  2. Read phy=1 reg=1, PHY model returns 16'h796D with TA 0 -> rsp_rdata=16'h796D, nack=0, out_en=0 for all TA/data bits.
//  3. Read with no PHY (line pulled high) -> rsp_nack=1, rsp_rdata=16'hFFFF, single rsp.
//  4. Poll reg=1 mask=16'h0004 match=16'h0004; model sets bit2 on 3rd read -> exactly one rsp after 3 frames, rdata[2]=1, timeout=0.
//  5. Poll with POLL_MAX=2, bit never set -> one rsp after 2 frames, rsp_timeout=1; then PRE_LEN=8 variant: latency 40 cycles.
//  6. Assert rst during FRAME bit 20 -> mdio_out_en=0 immediately; after release cmd_ready=1, no rsp_valid; next command completes normally.

Source files
------------

// File: rtl/mdio_master.sv
// Clause-22 MDIO (SMI) master: single read/write commands over valid/ready,
// open-drain MDIO drive, read-data/ACK response and optional poll-until-match.
module mdio_master #(
  parameter int unsigned PRE_LEN  = 32,
  parameter int unsigned IDLE_GAP = 4,
  parameter int unsigned POLL_MAX = 16
) (
  input  logic        clk1m,
  input  logic        rst,
  output logic        mdc_o,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_out_en,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic        cmd_poll,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  input  logic [15:0] cmd_mask,
  input  logic [15:0] cmd_match,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_nack,
  output logic        rsp_timeout,
  output logic        busy
);

  if (PRE_LEN == 0 || PRE_LEN > 63) begin : g_bad_pre_len
    $error("mdio_master: PRE_LEN must be in 1..63");
  end
  if (IDLE_GAP == 0 || IDLE_GAP > 255) begin : g_bad_idle_gap
    $error("mdio_master: IDLE_GAP must be in 1..255");
  end
  if (POLL_MAX > 255) begin : g_bad_poll_max
    $error("mdio_master: POLL_MAX must be in 0..255");
  end

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_FRAME, S_DONE, S_GAP} state_t;

  localparam logic [7:0] PRE_LAST = 8'(PRE_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(IDLE_GAP - 2);
  localparam logic [7:0] POLL_LIM = 8'(POLL_MAX);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        rw_q, poll_q;
  logic [4:0]  phy_q, reg_q;
  logic [15:0] wdata_q, mask_q, match_q;
  logic [14:0] shreg;
  logic        nack_q;
  logic [7:0]  attempt;
  logic        retry_q;

  logic        accept, last_bit, poll_on, is_match, at_limit, emit;
  logic [15:0] rd_word;
  logic [31:0] frame_word;

  assign mdc_o  = clk1m;
  assign mdio_o = 1'b0;

  assign accept     = (state == S_IDLE) && cmd_valid;
  assign last_bit   = (state == S_FRAME) && (cnt[4:0] == 5'd31);
  assign rd_word    = {shreg, mdio_i};
  assign poll_on    = rw_q && poll_q;
  assign is_match   = ((rd_word & mask_q) == match_q);
  assign at_limit   = (POLL_LIM != 8'd0) && (attempt == POLL_LIM);
  assign emit       = !poll_on || is_match || nack_q || at_limit;
  assign frame_word = {2'b01, rw_q ? 2'b10 : 2'b01, phy_q, reg_q,
                       rw_q ? 2'b11 : 2'b10, rw_q ? 16'hFFFF : wdata_q};

  // State register
  always_ff @(posedge clk1m or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic. DONE counts as the first released gap cycle, so GAP
  // itself lasts IDLE_GAP-1 cycles and the line stays released IDLE_GAP cycles.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (cmd_valid) state_nxt = S_PRE;
      S_PRE:   if (cnt == PRE_LAST) state_nxt = S_FRAME;
      S_FRAME: if (cnt[4:0] == 5'd31) state_nxt = S_DONE;
      S_DONE: begin
        if (IDLE_GAP == 1) state_nxt = retry_q ? S_PRE : S_IDLE;
        else               state_nxt = S_GAP;
      end
      S_GAP:   if (cnt == GAP_LAST) state_nxt = retry_q ? S_PRE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: handshake and open-drain enable for the current frame bit
  always_comb begin
    cmd_ready   = (state == S_IDLE);
    busy        = (state != S_IDLE);
    mdio_out_en = (state == S_FRAME) && !frame_word[5'd31 - cnt[4:0]];
  end

  // Per-state cycle counter, cleared on every state change
  always_ff @(posedge clk1m or negedge rst) begin
    if (!rst)                                     cnt <= '0;
    else if (state == S_IDLE || state_nxt != state) cnt <= '0;
    else                                          cnt <= cnt + 8'd1;
  end

  // Command capture, line sampling, poll bookkeeping and response generation
  always_ff @(posedge clk1m or negedge rst) begin
    if (!rst) begin
      rw_q        <= 1'b0;
      poll_q      <= 1'b0;
      phy_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      match_q     <= '0;
      shreg       <= '0;
      nack_q      <= 1'b0;
      attempt     <= '0;
      retry_q     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        rw_q    <= cmd_rw;
        poll_q  <= cmd_poll;
        phy_q   <= cmd_phy;
        reg_q   <= cmd_reg;
        wdata_q <= cmd_wdata;
        mask_q  <= cmd_mask;
        match_q <= cmd_match;
        attempt <= 8'd1;
        retry_q <= 1'b0;
      end
      if (state == S_FRAME) begin
        shreg <= {shreg[13:0], mdio_i};
        if (cnt[4:0] == 5'd15) nack_q <= mdio_i;
      end
      if (last_bit) begin
        retry_q <= !emit;
        if (emit) begin
          rsp_valid   <= 1'b1;
          rsp_rdata   <= rw_q ? rd_word : '0;
          rsp_nack    <= rw_q && nack_q;
          rsp_timeout <= poll_on && !is_match && !nack_q && at_limit;
        end else if (attempt != 8'hFF) begin
          attempt <= attempt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master: default instance plus a PRE_LEN=8 /
// POLL_MAX=2 instance, an MDIO PHY model at address 1, frame and response checks.
`timescale 1ns/1ps
module tb_mdio_master;

  typedef struct {
    logic [15:0] rdata;
    logic        nack;
    logic        tmo;
    int unsigned t0;
    int unsigned lat;
  } exp_t;

  logic        clk1m = 1'b0;
  logic        rst   = 1'b0;
  logic        sel   = 1'b0;
  logic        cmd_valid = 1'b0, cmd_rw = 1'b0, cmd_poll = 1'b0;
  logic [4:0]  cmd_phy = '0, cmd_reg = '0;
  logic [15:0] cmd_wdata = '0, cmd_mask = '0, cmd_match = '0;
  logic        phy_drv = 1'b1;
  logic        line;

  logic        cv [2];
  logic        mdc [2], mo [2], oe [2], rdy [2], rv [2], nk [2], tm [2], bz [2];
  logic [15:0] rd [2];

  logic        m_oe, m_ready, m_rv, m_nack, m_tmo;
  logic [15:0] m_rdata;

  exp_t        rsp_q[$];
  logic [31:0] frame_q[$];
  logic [15:0] phy_q[$];
  int unsigned n_cmp = 0, n_bad = 0, cyc = 0;

  always #5 clk1m = ~clk1m;
  always @(posedge clk1m) cyc <= cyc + 1;

  assign cv[0]   = cmd_valid & ~sel;
  assign cv[1]   = cmd_valid & sel;
  assign m_oe    = sel ? oe[1]  : oe[0];
  assign m_ready = sel ? rdy[1] : rdy[0];
  assign m_rv    = sel ? rv[1]  : rv[0];
  assign m_nack  = sel ? nk[1]  : nk[0];
  assign m_tmo   = sel ? tm[1]  : tm[0];
  assign m_rdata = sel ? rd[1]  : rd[0];
  assign line    = ~m_oe & phy_drv;

  mdio_master u0 (
    .clk1m(clk1m), .rst(rst), .mdc_o(mdc[0]), .mdio_i(line), .mdio_o(mo[0]),
    .mdio_out_en(oe[0]), .cmd_valid(cv[0]), .cmd_ready(rdy[0]), .cmd_rw(cmd_rw),
    .cmd_poll(cmd_poll), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .cmd_mask(cmd_mask), .cmd_match(cmd_match), .rsp_valid(rv[0]), .rsp_rdata(rd[0]),
    .rsp_nack(nk[0]), .rsp_timeout(tm[0]), .busy(bz[0])
  );

  mdio_master #(.PRE_LEN(8), .POLL_MAX(2)) u1 (
    .clk1m(clk1m), .rst(rst), .mdc_o(mdc[1]), .mdio_i(line), .mdio_o(mo[1]),
    .mdio_out_en(oe[1]), .cmd_valid(cv[1]), .cmd_ready(rdy[1]), .cmd_rw(cmd_rw),
    .cmd_poll(cmd_poll), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .cmd_mask(cmd_mask), .cmd_match(cmd_match), .rsp_valid(rv[1]), .rsp_rdata(rd[1]),
    .rsp_nack(nk[1]), .rsp_timeout(tm[1]), .busy(bz[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_oe(input logic rw, input logic [4:0] phy,
                                         input logic [4:0] rg, input logic [15:0] wd);
    logic [31:0] b;
    b = {2'b01, rw ? 2'b10 : 2'b01, phy, rg, rw ? 2'b11 : 2'b10, rw ? 16'hFFFF : wd};
    return ~b;
  endfunction

  // Response monitor: pops the oldest expectation on every rsp_valid
  always @(negedge clk1m) begin : mon
    exp_t e;
    if (rst && m_rv) begin
      if (rsp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = rsp_q.pop_front();
        chk("rsp_rdata", {16'h0, m_rdata}, {16'h0, e.rdata});
        chk("rsp_nack", {31'h0, m_nack}, {31'h0, e.nack});
        chk("rsp_timeout", {31'h0, m_tmo}, {31'h0, e.tmo});
        chk("rsp_latency", cyc - e.t0, e.lat);
      end
    end
  end

  // PHY model at address 1: decodes frames from the line, answers reads,
  // drives its bits in the second half of each bit window
  int          fcnt = -1;
  logic        prev_one = 1'b1, rd_act = 1'b0;
  logic [31:0] fr = '0;
  logic [15:0] rd_data = '0;
  always @(negedge clk1m) begin
    phy_drv = 1'b1;
    if (!rst) begin
      fcnt = -1; prev_one = 1'b1; rd_act = 1'b0;
    end else if (fcnt < 0) begin
      if (prev_one && m_oe) begin
        fcnt = 0; fr = '0; fr[31] = 1'b1; rd_act = 1'b0;
      end
      prev_one = ~m_oe;
    end else begin
      fcnt++;
      fr[31 - fcnt] = m_oe;
      if (fcnt == 13) begin
        rd_act = (fr[29:28] == 2'b01) && (fr[27:23] == 5'b11110);
        if (rd_act) rd_data = (phy_q.size() != 0) ? phy_q.pop_front() : 16'hDEAD;
      end
      if (rd_act && fcnt >= 14)
        phy_drv = (fcnt == 14) ? 1'b1 : (fcnt == 15) ? 1'b0 : rd_data[31 - fcnt];
      if (fcnt == 31) begin
        if (frame_q.size() == 0) chk("unexpected_frame", 32'd1, 32'd0);
        else                     chk("frame_oe", fr, frame_q.pop_front());
        fcnt = -1; prev_one = 1'b0;
      end
    end
  end

  task automatic issue(input logic rw, input logic poll, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [15:0] wd, input logic [15:0] mk,
                       input logic [15:0] mt, input logic [31:0] efr, input int unsigned nfr,
                       input logic [15:0] e_rd, input logic e_nack, input logic e_tmo,
                       input int unsigned lat, input logic want_rsp);
    int unsigned w;
    exp_t e;
    w = 0;
    @(negedge clk1m);
    cmd_rw = rw; cmd_poll = poll; cmd_phy = phy; cmd_reg = rg;
    cmd_wdata = wd; cmd_mask = mk; cmd_match = mt; cmd_valid = 1'b1;
    while (!m_ready && w < 2000) begin
      @(negedge clk1m);
      w++;
    end
    if (!m_ready) begin
      chk("accept_wait", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk1m);
    @(negedge clk1m);
    cmd_valid = 1'b0;
    cmd_rw = ~rw; cmd_poll = ~poll; cmd_phy = ~phy; cmd_reg = ~rg;
    cmd_wdata = ~wd; cmd_mask = ~mk; cmd_match = ~mt;
    for (int i = 0; i < int'(nfr); i++) frame_q.push_back(efr);
    if (want_rsp) begin
      e.rdata = e_rd; e.nack = e_nack; e.tmo = e_tmo; e.t0 = cyc; e.lat = lat;
      rsp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int unsigned w;
    w = 0;
    while ((rsp_q.size() != 0 || !m_ready) && w < 3000) begin
      @(negedge clk1m);
      w++;
    end
    repeat (8) @(negedge clk1m);
    chk({name, "_rsp_left"}, rsp_q.size(), 32'd0);
    chk({name, "_frames_left"}, frame_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk1m);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", {31'h0, rdy[i]}, 32'd1);
      chk("rst_busy", {31'h0, bz[i]}, 32'd0);
      chk("rst_oe", {31'h0, oe[i]}, 32'd0);
      chk("rst_rsp_valid", {31'h0, rv[i]}, 32'd0);
      chk("rst_rdata", {16'h0, rd[i]}, 32'd0);
      chk("rst_nack_tmo", {30'h0, nk[i], tm[i]}, 32'd0);
      chk("mdio_o", {31'h0, mo[i]}, 32'd0);
      chk("mdc", {31'h0, mdc[i]}, {31'h0, clk1m});
    end
    @(posedge clk1m); #1 rst = 1'b1;

    // Write phy=1 reg=31 data=0x0007
    issue(1'b0, 1'b0, 5'd1, 5'd31, 16'h0007, 16'h0, 16'h0,
          ~32'b01_01_00001_11111_10_0000000000000111, 1, 16'h0000, 1'b0, 1'b0, 64, 1'b1);
    // Read phy=1 reg=1, PHY answers 0x796D (back-to-back with the write)
    phy_q.push_back(16'h796D);
    issue(1'b1, 1'b0, 5'd1, 5'd1, 16'h0, 16'h0, 16'h0, exp_oe(1'b1, 5'd1, 5'd1, 16'h0),
          1, 16'h796D, 1'b0, 1'b0, 64, 1'b1);
    // Read with no PHY at address 5: line stays high
    issue(1'b1, 1'b0, 5'd5, 5'd1, 16'h0, 16'h0, 16'h0, exp_oe(1'b1, 5'd5, 5'd1, 16'h0),
          1, 16'hFFFF, 1'b1, 1'b0, 64, 1'b1);
    // Poll bit 2, set on the 3rd read: 3*64 + 2*4 cycles
    phy_q.push_back(16'h7969); phy_q.push_back(16'h7969); phy_q.push_back(16'h796D);
    issue(1'b1, 1'b1, 5'd1, 5'd1, 16'h0, 16'h0004, 16'h0004, exp_oe(1'b1, 5'd1, 5'd1, 16'h0),
          3, 16'h796D, 1'b0, 1'b0, 200, 1'b1);
    // Poll against an absent PHY: nack ends polling after one frame
    issue(1'b1, 1'b1, 5'd5, 5'd2, 16'h0, 16'h0004, 16'h0000, exp_oe(1'b1, 5'd5, 5'd2, 16'h0),
          1, 16'hFFFF, 1'b1, 1'b0, 64, 1'b1);
    // Poll flag on a write is ignored; rdata returns to zero
    issue(1'b0, 1'b1, 5'd2, 5'd3, 16'hA5C3, 16'hFFFF, 16'h1234, exp_oe(1'b0, 5'd2, 5'd3, 16'hA5C3),
          1, 16'h0000, 1'b0, 1'b0, 64, 1'b1);
    drain("seq0");

    // Reset during frame bit 20 of a write (data bit wdata[11]=0 drives low)
    issue(1'b0, 1'b0, 5'd1, 5'd2, 16'h0000, 16'h0, 16'h0, 32'h0, 0, 16'h0, 1'b0, 1'b0, 0, 1'b0);
    repeat (52) @(posedge clk1m);
    #2;
    chk("oe_before_reset", {31'h0, m_oe}, 32'd1);
    rst = 1'b0;
    #1;
    chk("oe_on_reset", {31'h0, m_oe}, 32'd0);
    chk("ready_on_reset", {31'h0, m_ready}, 32'd1);
    repeat (3) @(negedge clk1m);
    @(posedge clk1m); #1 rst = 1'b1;
    repeat (100) @(negedge clk1m);
    chk("ready_after_reset", {31'h0, m_ready}, 32'd1);
    chk("rdata_after_reset", {16'h0, m_rdata}, 32'd0);
    issue(1'b0, 1'b0, 5'd3, 5'd4, 16'hFFFF, 16'h0, 16'h0, exp_oe(1'b0, 5'd3, 5'd4, 16'hFFFF),
          1, 16'h0000, 1'b0, 1'b0, 64, 1'b1);
    drain("seq1");

    // PRE_LEN=8, POLL_MAX=2 instance
    @(negedge clk1m); sel = 1'b1;
    phy_q.push_back(16'h0000); phy_q.push_back(16'h0000);
    issue(1'b1, 1'b1, 5'd1, 5'd1, 16'h0, 16'h0004, 16'h0004, exp_oe(1'b1, 5'd1, 5'd1, 16'h0),
          2, 16'h0000, 1'b0, 1'b1, 84, 1'b1);
    phy_q.push_back(16'h1234);
    issue(1'b1, 1'b0, 5'd1, 5'd7, 16'h0, 16'h0, 16'h0, exp_oe(1'b1, 5'd1, 5'd7, 16'h0),
          1, 16'h1234, 1'b0, 1'b0, 40, 1'b1);
    drain("seq2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
